// File: rtl/ula_op_sequencer.sv
// Front-end sequencer for the ULA operation decoder: queues 3-bit op codes and
// plays each one onto SEL/EN for HOLD cycles, followed by one idle/DONE cycle.
module ula_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [2:0]             op_in_i,
  input  logic                   op_valid_i,
  output logic                   op_ready_o,
  output logic [2:0]             sel_o,
  output logic                   en_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [AW:0] FULL      = (AW + 1)'(DEPTH);
  localparam logic [3:0]  HOLD_INIT = 4'(HOLD - 1);

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    hold_q, hold_d;
  logic [2:0]    sel_q, sel_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          push, pop;

  // Ready comes from the registered count only, so a pop never frees a slot
  // for a push on the same edge.
  assign op_ready_o = (count_q != FULL);
  assign push       = op_valid_i && op_ready_o;
  assign pop        = ((state_q == ST_IDLE) || (state_q == ST_GAP)) && (count_q != '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    en_d    = en_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        sel_d = 3'b000;
        en_d  = 1'b0;
        if (pop) begin
          state_d = ST_ISSUE;
          hold_d  = HOLD_INIT;
          sel_d   = mem_q[rd_ptr_q];
          en_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (hold_q == 4'd0) begin
          state_d = ST_GAP;
          sel_d   = 3'b000;
          en_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 3'b000;
        en_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      sel_q    <= 3'b000;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) begin
      mem_q[wr_ptr_q] <= op_in_i;
    end
  end

  assign sel_o   = sel_q;
  assign en_o    = en_q;
  assign done_o  = done_q;
  assign count_o = count_q;
  assign busy_o  = (state_q != ST_IDLE) || (count_q != '0);

endmodule
